// File: rtl/ram_capture_ctrl_if.sv
// Stream and RAM-port bundle for ram_capture_ctrl: control, capture input,
// playback output and the single_port_ram pins it owns.
interface ram_capture_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [ADDR_WIDTH:0]   length;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, length, s_data, s_valid, m_ready, ram_dout,
        output s_ready, m_data, m_valid, m_last, ram_we, ram_addr, ram_din, busy, done
    );

    modport slave (
        output start, length, s_data, s_valid, m_ready, ram_dout,
        input  s_ready, m_data, m_valid, m_last, ram_we, ram_addr, ram_din, busy, done
    );
endinterface

// File: rtl/ram_capture_ctrl.sv
// Captures a burst from a valid/ready stream into single_port_ram, then plays it
// back in write order through a 2-entry FIFO that hides the RAM read latency.
module ram_capture_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int RAM_DEPTH  = 4096
) (
    input  logic clk,
    input  logic rst,
    ram_capture_ctrl_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READ    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PTR_WIDTH-1:0]  r_len;
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_head;
    logic [1:0]            r_count;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic [PTR_WIDTH-1:0]  w_len_req;
    logic [PTR_WIDTH-1:0]  w_len_m1;
    logic [2:0]            w_occ;
    logic                  w_m_valid;
    logic                  w_pop;
    logic                  w_final_pop;
    logic                  w_tail;
    logic                  w_issue;
    logic                  w_wr_fire;
    logic                  w_wr_final;
    logic                  w_s_ready;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_din;

    assign w_len_req   = (bus.length > PTR_WIDTH'(RAM_DEPTH)) ? PTR_WIDTH'(RAM_DEPTH) : bus.length;
    assign w_len_m1    = r_len - PTR_WIDTH'(1);
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_m_valid   = (r_state == ST_READ) && (r_count != 2'd0);
    assign w_pop       = w_m_valid && bus.m_ready;
    assign w_final_pop = w_pop && r_fifo_last[r_head];
    assign w_tail      = r_head ^ r_count[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_din   = '0;
        w_wr_fire   = 1'b0;
        w_wr_final  = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && (w_len_req != '0)) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_s_ready  = 1'b1;
                w_ram_we   = bus.s_valid;
                w_ram_addr = r_wr_ptr[ADDR_WIDTH-1:0];
                w_ram_din  = bus.s_data;
                w_wr_fire  = bus.s_valid;
                w_wr_final = bus.s_valid && (r_wr_ptr == w_len_m1);
                if (w_wr_final) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_ram_addr = r_rd_ptr[ADDR_WIDTH-1:0];
                // A same-cycle pop frees a slot, which keeps playback at one sample per clock.
                w_issue = (r_rd_ptr < r_len) &&
                          ((w_occ < 3'd2) || (w_pop && (w_occ < 3'd3)));
                if (w_final_pop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len           <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= '0;
            r_head          <= 1'b0;
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= ((r_state == ST_IDLE) && bus.start && (w_len_req == '0)) || w_final_pop;

            if ((r_state == ST_IDLE) && bus.start) begin
                r_len    <= w_len_req;
                r_wr_ptr <= '0;
            end else if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end

            if (w_wr_final) begin
                r_rd_ptr <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_last <= (r_rd_ptr == w_len_m1);
            end

            // RAM output is valid the cycle after issue; park it at the FIFO tail.
            if (r_inflight) begin
                r_fifo_data[w_tail] <= bus.ram_dout;
                r_fifo_last[w_tail] <= r_inflight_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.ram_we   = w_ram_we;
    assign bus.ram_addr = w_ram_addr;
    assign bus.ram_din  = w_ram_din;
    assign bus.m_valid  = w_m_valid;
    assign bus.m_data   = w_m_valid ? r_fifo_data[r_head] : '0;
    assign bus.m_last   = w_m_valid && r_fifo_last[r_head];
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
endmodule

// File: tb/tb_ram_capture_ctrl.sv
// Directed bench for ram_capture_ctrl with a behavioural single-port RAM and a
// queue scoreboard of captured samples checked against playback.
module tb_ram_capture_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_capture_ctrl_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12)) bus ();

    ram_capture_ctrl #(.DATA_WIDTH(12), .RAM_DEPTH(4096)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [11:0] ram_mem [4096];
    logic [11:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
        ram_q <= ram_mem[bus.ram_addr];
    end
    assign bus.ram_dout = ram_q;

    int checks   = 0;
    int failures = 0;
    logic [11:0] q_data [$];
    logic        q_last [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    32'(bus.busy),     0);
        chk({tag, "_done"},    32'(bus.done),     0);
        chk({tag, "_s_ready"}, 32'(bus.s_ready),  0);
        chk({tag, "_m_valid"}, 32'(bus.m_valid),  0);
        chk({tag, "_m_data"},  32'(bus.m_data),   0);
        chk({tag, "_m_last"},  32'(bus.m_last),   0);
        chk({tag, "_ram_we"},  32'(bus.ram_we),   0);
        chk({tag, "_ram_addr"},32'(bus.ram_addr), 0);
    endtask

    // gap: 0 back-to-back data n+1, 1 random gaps/data; rdy: 0 always, 1 toggle, 2 random.
    task automatic run_burst(input int req, input int gap, input int rdy,
                             input bit restart, input bit abort);
        int L, n, cyc, outs, first, last_cyc;
        logic [11:0] d;
        L = (req > 4096) ? 4096 : req;
        bus.start  = 1'b1;
        bus.length = 13'(req);
        @(negedge clk);
        chk("start_busy", 32'(bus.busy), 0);
        chk("start_sready", 32'(bus.s_ready), 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (L == 0) begin
            @(negedge clk);
            chk("zero_done", 32'(bus.done), 1);
            chk("zero_busy", 32'(bus.busy), 0);
            chk("zero_we", 32'(bus.ram_we), 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("zero_done_clr", 32'(bus.done), 0);
            chk("zero_busy2", 32'(bus.busy), 0);
            @(posedge clk); #1;
        end else begin
            n = 0; cyc = 0;
            while (n < L && cyc < L * 4 + 20) begin
                bus.s_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                d = (gap == 0) ? 12'(n + 1) : 12'($urandom_range(0, 4095));
                bus.s_data = d;
                if (restart && n == 1) begin
                    bus.start  = 1'b1;
                    bus.length = 13'd2;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                chk("cap_busy", 32'(bus.busy), 1);
                chk("cap_sready", 32'(bus.s_ready), 1);
                chk("cap_mvalid", 32'(bus.m_valid), 0);
                chk("cap_we", 32'(bus.ram_we), 32'(bus.s_valid));
                if (bus.s_valid) begin
                    chk("cap_addr", 32'(bus.ram_addr), 32'(n));
                    chk("cap_din", 32'(bus.ram_din), 32'(d));
                    q_data.push_back(d);
                    q_last.push_back(n == L - 1);
                    n++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            bus.s_valid = 1'b0;
            bus.start   = 1'b0;
            chk("cap_count", 32'(n), 32'(L));

            outs = 0; cyc = 0; first = -1; last_cyc = -1;
            while (outs < L && cyc < L * 4 + 20) begin
                case (rdy)
                    0:       bus.m_ready = 1'b1;
                    1:       bus.m_ready = (cyc % 2 == 0);
                    default: bus.m_ready = ($urandom_range(0, 1) == 1);
                endcase
                if (abort) bus.m_ready = 1'b0;
                @(negedge clk);
                chk("rd_sready", 32'(bus.s_ready), 0);
                chk("rd_we", 32'(bus.ram_we), 0);
                chk("rd_busy", 32'(bus.busy), 1);
                if (bus.m_valid) begin
                    if (first < 0) first = cyc;
                    if (q_data.size() == 0) begin
                        chk("rd_extra", 32'(bus.m_valid), 0);
                    end else begin
                        chk("rd_data", 32'(bus.m_data), 32'(q_data[0]));
                        chk("rd_last", 32'(bus.m_last), 32'(q_last[0]));
                        if (bus.m_ready) begin
                            void'(q_data.pop_front());
                            void'(q_last.pop_front());
                            outs++;
                            last_cyc = cyc;
                        end
                    end
                end
                if (abort && cyc == 4) begin
                    #1 rst = 1'b1;
                    #1 chk_idle_outputs("abort");
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk_idle_outputs("abort_hold");
                    #1 rst = 1'b0;
                    q_data.delete();
                    q_last.delete();
                    break;
                end
                @(posedge clk); #1;
                cyc++;
            end
            bus.m_ready = 1'b0;
            if (!abort) begin
                chk("rd_count", 32'(outs), 32'(L));
                chk("rd_first_valid", 32'(first), 2);
                if (rdy == 0) chk("rd_full_rate", 32'(last_cyc), 32'(L + 1));
                @(negedge clk);
                chk("end_done", 32'(bus.done), 1);
                chk("end_busy", 32'(bus.busy), 0);
                chk("end_mvalid", 32'(bus.m_valid), 0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("end_done_clr", 32'(bus.done), 0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.length  = '0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #3;
        chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");
        @(posedge clk); #1;

        run_burst(4,    0, 0, 1'b0, 1'b0);
        run_burst(8,    0, 1, 1'b0, 1'b0);
        run_burst(6,    1, 2, 1'b0, 1'b0);
        run_burst(5,    1, 0, 1'b1, 1'b0);
        run_burst(0,    0, 0, 1'b0, 1'b0);
        run_burst(3,    0, 0, 1'b0, 1'b1);
        run_burst(2,    0, 0, 1'b0, 1'b0);
        run_burst(5000, 1, 2, 1'b0, 1'b0);
        run_burst(4,    1, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
